determinant_bcd_converter: RTL



---
 rtl/determinant_bcd_converter_pkg.sv | 22 ++
 rtl/determinant_bcd_converter_bcd_add3_digit.sv | 12 +
 rtl/determinant_bcd_converter.sv | 94 +++++++++
 3 files changed

// File: rtl/determinant_bcd_converter_pkg.sv
// rtl/determinant_bcd_converter_pkg.sv - shared widths, helpers and FSM encoding
// for the determinant-to-BCD converter.
package determinant_bcd_converter_pkg;

  localparam int BCD_DIGIT_W = 4;

  // Determinant width N for a given matrix element width.
  function automatic int det_width(input int width);
    return 4 * width;
  endfunction

  // Iteration counter width: must be able to hold the value N.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

endpackage

// File: rtl/determinant_bcd_converter_bcd_add3_digit.sv
// rtl/determinant_bcd_converter_bcd_add3_digit.sv - one double-dabble digit
// correction: add 3 when the digit is 5 or more.
module bcd_add3_digit
  import determinant_bcd_converter_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  assign digit_out = (digit_in >= BCD_DIGIT_W'(5)) ? digit_in + BCD_DIGIT_W'(3) : digit_in;

endmodule

// File: rtl/determinant_bcd_converter.sv
// rtl/determinant_bcd_converter.sv - sequential sign/magnitude to packed BCD
// converter with start/busy/done handshake.
module determinant_bcd_converter
  import determinant_bcd_converter_pkg::*;
#(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [4*WIDTH-1:0]            determinant,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          negative,
  output logic                          busy,
  output logic                          done
);

  localparam int N     = det_width(WIDTH);
  localparam int CNT_W = cnt_width(N);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

  state_t             state, state_next;
  logic [N-1:0]       mag, mag_shifted;
  logic               sign;
  logic [BCD_W-1:0]   scratch, adjusted, scratch_shifted;
  logic [CNT_W-1:0]   cnt;
  logic               accept, last_iter;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_in  (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out (adjusted[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign {scratch_shifted, mag_shifted} = {adjusted, mag} << 1;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_iter  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        busy = 1'b1;
        if (cnt == LAST_ITER) begin
          last_iter  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mag      <= '0;
      sign     <= 1'b0;
      scratch  <= '0;
      cnt      <= '0;
      bcd      <= '0;
      negative <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_next;
      done  <= last_iter;
      if (accept) begin
        // -(-2^(N-1)) wraps to 2^(N-1), which is the correct unsigned magnitude.
        mag     <= determinant[N-1] ? -determinant : determinant;
        sign    <= determinant[N-1];
        scratch <= '0;
        cnt     <= '0;
      end else if (state == CONV) begin
        scratch <= scratch_shifted;
        mag     <= mag_shifted;
        cnt     <= cnt + CNT_W'(1);
        if (last_iter) begin
          bcd      <= scratch_shifted;
          negative <= sign;
        end
      end
    end
  end

endmodule
